// File: rtl/controller.sv
// Eight-phase instruction sequencer: fetch/decode/execute strobes and HLT.
// Optional resume-from-halt is enabled by defining CTRL_RESUME_EN.
module controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  input  logic       resume,
  output logic       sel,
  output logic       rd,
  output logic       wr,
  output logic       data_e,
  output logic       ld_ir,
  output logic       ld_ac,
  output logic       ld_pc,
  output logic       inc_pc,
  output logic       halt,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  phase_e phase_q, phase_d;
  logic   halted_q, halted_d;
  logic   aluop;

  assign aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                 (opcode == OP_XOR) || (opcode == OP_LDA);

`ifndef CTRL_RESUME_EN
  logic unused_resume;
  assign unused_resume = resume;
`endif

  always_comb begin
    phase_d  = phase_e'(phase_q + 3'd1);
    halted_d = halted_q;
    if (halted_q) begin
      phase_d = phase_q;
`ifdef CTRL_RESUME_EN
      if (resume) begin
        halted_d = 1'b0;
        phase_d  = INST_ADDR;
      end
`endif
    end else if (phase_q == OP_ADDR && opcode == OP_HLT) begin
      // PC has already been bumped once in this phase; freeze here.
      halted_d = 1'b1;
      phase_d  = OP_ADDR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    inc_pc = 1'b0;
    halt   = 1'b0;
    if (rst) begin
      sel = 1'b1;
    end else if (halted_q) begin
      halt = 1'b1;
    end else begin
      unique case (phase_q)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (opcode == OP_HLT);
        end
        OP_FETCH: begin
          rd = aluop;
        end
        ALU_OP: begin
          // Drive the bus a phase ahead of the STO write edge.
          rd     = aluop;
          inc_pc = (opcode == OP_SKZ) && zero;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
        end
        STORE: begin
          rd     = aluop;
          ld_ac  = aluop;
          ld_pc  = (opcode == OP_JMP);
          wr     = (opcode == OP_STO);
          data_e = (opcode == OP_STO);
        end
        default: ;
      endcase
    end
  end

  assign phase = phase_q;

endmodule

// File: doc/controller.md
# controller

Instruction-sequencing controller for the RISC CPU. An 8-phase state machine steps through fetch, decode, operand-fetch and execute for each instruction. It drives the control strobes consumed by the memory (`rd`, `wr`, `data_e`), the address mux (`sel`), and the PC/IR/accumulator registers. It sits directly upstream of the memory and owns the HLT behaviour.

## Interface
- Parameters: none. Opcode width is fixed at 3 bits. Data and address widths are not used.
- `clk` input 1: single system clock. All state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `opcode` input 3: instruction register opcode field. HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- `zero` input 1: accumulator-is-zero flag, sampled combinationally.
- `resume` input 1: leaves the halted state. Honoured only with `CTRL_RESUME_EN`; ignored otherwise.
- `sel` output 1: address mux select. 1 selects PC, 0 selects the IR address field.
- `rd` output 1: memory read enable.
- `wr` output 1: memory write enable.
- `data_e` output 1: data output enable (accumulator onto the bus).
- `ld_ir` output 1: load the instruction register.
- `ld_ac` output 1: load the accumulator.
- `ld_pc` output 1: load the PC from the IR address.
- `inc_pc` output 1: increment the PC.
- `halt` output 1: CPU halted indicator.
- `phase` output 3: current phase, for debug and bench use.

## Operation
- State consists of a 3-bit `phase` register and a 1-bit `halted` flag.
- Phases:
  - INST_ADDR=0, INST_FETCH=1, INST_LOAD=2, IDLE=3
  - OP_ADDR=4, OP_FETCH=5, ALU_OP=6, STORE=7
- Normal transition is phase+1, with wrap 7→0. One instruction takes exactly 8 cycles.
- ALUOP = opcode ∈ {ADD, AND, XOR, LDA}.
- Outputs are a combinational decode of `phase`, `opcode`, `zero` and `halted`. Any strobe not listed for a phase is 0.
  - INST_ADDR: `sel`=1.
  - INST_FETCH: `sel`=1, `rd`=1.
  - INST_LOAD: `sel`=1, `rd`=1, `ld_ir`=1.
  - IDLE: `sel`=1, `rd`=1, `ld_ir`=1.
  - OP_ADDR: `inc_pc`=!`halted`; `halt`=`halted` OR (opcode==HLT).
  - OP_FETCH: `rd`=ALUOP.
  - ALU_OP:
    - `rd`=ALUOP
    - `inc_pc`=(opcode==SKZ && `zero`)
    - `ld_pc`=(opcode==JMP)
    - `data_e`=(opcode==STO)
  - STORE:
    - `rd`=ALUOP
    - `ld_ac`=ALUOP
    - `ld_pc`=(opcode==JMP)
    - `wr`=(opcode==STO)
    - `data_e`=(opcode==STO)
- HLT handling:
  - In OP_ADDR with opcode==HLT, `phase` holds at OP_ADDR and `halted` is set to 1 on that edge.
  - PC is therefore incremented exactly once and points past the HLT instruction.
  - While halted, `phase` stays at 4, `halt`=1, and every other strobe is 0.
  - The `opcode` value is don't-care while halted.
- A STO write is issued only in STORE (`wr`=1 and `data_e`=1 together). `data_e` is asserted one phase early, in ALU_OP, so the bus is driven before the write edge.
- `rd` and `data_e` are never both 1 in any phase.

## Timing
- Reset:
  - On a rising edge with `rst`=1: `phase` becomes 0 and `halted` becomes 0.
  - While `rst`=1, outputs are forced to the INST_ADDR decode: `sel`=1, all other strobes 0, `halt`=0.
  - Reset takes priority over `resume` and over HLT. A reset mid-instruction abandons that instruction with no further strobes.
- `rst` deasserted at edge N: INST_ADDR is visible in cycle N. INST_FETCH follows at edge N+1.
- Output latency: strobes change only with `phase`/`halted`, i.e. just after the clock edge. The exceptions are `zero`/`opcode`, which feed through combinationally.
- `opcode` must be stable from the end of INST_LOAD through STORE. `ld_ir` asserts in INST_LOAD and IDLE; the IR captures at the IDLE→OP_ADDR edge.
- SKZ: `inc_pc` is a single 1-cycle pulse in ALU_OP. This gives a total PC advance of 2 for that instruction.

## Configuration
- `CTRL_RESUME_EN` defined:
  - When `halted`=1 and `resume`=1 at a rising edge, `halted` is cleared and `phase` becomes INST_ADDR.
  - Execution continues at the instruction after the HLT.
  - During the cycle `resume` is sampled, outputs remain the halted decode.
  - `resume` while not halted is ignored.
- `CTRL_RESUME_EN` undefined: `resume` is ignored. Halt is sticky and only `rst` clears it.

## Test plan
- Reset held 3 cycles, then released with opcode=ADD, `zero`=0.
  - `phase` runs 0..7 then 0.
  - `rd`=1 in phases 1,2,3,5,6,7.
  - `ld_ac`=1 only in phase 7.
  - `inc_pc`=1 only in phase 4.
- opcode=STO:
  - `data_e`=1 in phases 6 and 7.
  - `wr`=1 only in phase 7.
  - `rd`=0 in phases 5–7.
- opcode=SKZ:
  - With `zero`=1: `inc_pc` pulses in phases 4 and 6.
  - With `zero`=0: `inc_pc` pulses only in phase 4.
  - opcode=JMP: `ld_pc`=1 in phases 6 and 7.
- opcode=HLT reaching phase 4:
  - `inc_pc`=1 for exactly one cycle, then 0.
  - `halt`=1 persists for 20+ cycles with `phase`=4.
  - Changing opcode to ADD while halted changes no output.
- Halted, `resume` pulsed 1 cycle.
  - With `CTRL_RESUME_EN`: `phase`=0 next cycle, `halt`=0.
  - Without it: remains halted.
  - After either, `rst` returns `phase` to 0 and `halt`=0.
- `rst` asserted in phase 6 with opcode=STO: next cycle `phase`=0 and `wr`=`data_e`=0. No write strobe ever appears.
